// File: rtl/instr_stack_ram_pkg.sv
// Shared definitions for the instruction stack RAM: default sizing, FSM encoding
// and the fetch range check.
package instr_stack_ram_pkg;

  localparam int unsigned DEF_WORD_W      = 16;
  localparam int unsigned DEF_DEPTH       = 256;
  localparam int unsigned DEF_INSTR_WORDS = 2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The whole instruction must lie below the loaded word count; no wrap-around.
  function automatic logic fetch_in_range(input int unsigned addr,
                                          input int unsigned words,
                                          input int unsigned count);
    return (addr + words) <= count;
  endfunction

endpackage

// File: rtl/instr_stack_ram_if.sv
// Load and fetch buses of the instruction stack RAM.
interface instr_stack_ram_if
  import instr_stack_ram_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned INSTR_WORDS = DEF_INSTR_WORDS,
  localparam int unsigned AW         = $clog2(DEPTH)
);

  logic                          ld_valid;
  logic [WORD_W-1:0]             ld_data;
  logic                          ld_last;
  logic                          ld_ready;
  logic                          fetch_req;
  logic [AW-1:0]                 fetch_addr;
  logic                          fetch_valid;
  logic [WORD_W*INSTR_WORDS-1:0] fetch_instr;
  logic                          fetch_err;

  modport master (
    output ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    input  ld_ready, fetch_valid, fetch_instr, fetch_err
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
    output ld_ready, fetch_valid, fetch_instr, fetch_err
  );

endinterface

// File: rtl/instr_stack_ram_stack_mem.sv
// Word memory with one write port and an INSTR_WORDS-wide registered read port.
// Contents are never reset.
module stack_mem
  import instr_stack_ram_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned INSTR_WORDS = DEF_INSTR_WORDS,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [WORD_W-1:0]             wdata,
  input  logic                          re,
  input  logic [AW-1:0]                 raddr,
  output logic [WORD_W*INSTR_WORDS-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Word k of the instruction lands in slice k; out-of-range reads are masked upstream.
  always_ff @(posedge clk) begin
    if (re) begin
      for (int unsigned k = 0; k < INSTR_WORDS; k++) begin
        rdata[k*WORD_W +: WORD_W] <= mem[raddr + AW'(k)];
      end
    end
  end

endmodule

// File: rtl/instr_stack_ram.sv
// Instruction stack RAM: programs are pushed word by word in LOAD, then fetched
// as multi-word instructions in RUN.
module instr_stack_ram
  import instr_stack_ram_pkg::*;
#(
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned INSTR_WORDS = DEF_INSTR_WORDS,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_stack_ram_if.slave    bus,
  input  logic                clear,
  output logic [AW:0]         sp,
  output logic                full,
  output logic                ld_overflow,
  output logic                initialized
);

  state_t                        state;
  logic                          fetch_valid_q;
  logic                          fetch_err_q;
  logic                          have_data;
  logic [WORD_W*INSTR_WORDS-1:0] rdata;
  logic                          accept;
  logic                          re;
  logic                          in_range;

  assign full          = (sp == (AW+1)'(DEPTH));
  assign initialized   = (state == RUN);
  assign bus.ld_ready  = (state == LOAD) && !full;
  assign accept        = bus.ld_valid && bus.ld_ready && !clear;
  assign re            = bus.fetch_req && !clear;
  assign in_range      = fetch_in_range(32'(bus.fetch_addr), INSTR_WORDS, 32'(sp));

  // The memory read register has no reset, so the visible instruction is gated
  // until a response has been produced and is forced to zero on error.
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_instr = (have_data && !fetch_err_q) ? rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      sp            <= '0;
      ld_overflow   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      have_data     <= 1'b0;
    end else if (clear) begin
      state         <= LOAD;
      sp            <= '0;
      ld_overflow   <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        sp <= sp + 1'b1;
        if (bus.ld_last) state <= RUN;
      end
      if (bus.ld_valid && (state == LOAD) && full) ld_overflow <= 1'b1;
      fetch_valid_q <= bus.fetch_req;
      if (bus.fetch_req) begin
        fetch_err_q <= (state != RUN) || !in_range;
        have_data   <= 1'b1;
      end
    end
  end

  stack_mem #(
    .WORD_W      (WORD_W),
    .DEPTH       (DEPTH),
    .INSTR_WORDS (INSTR_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (sp[AW-1:0]),
    .wdata (bus.ld_data),
    .re    (re),
    .raddr (bus.fetch_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_instr_stack_ram.sv
// Directed vector bench for instr_stack_ram (default sizing plus a DEPTH=8 copy).
module tb_instr_stack_ram;
  import instr_stack_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic clear8 = 1'b0;

  logic [8:0] sp;
  logic       full, ld_overflow, initialized;
  logic [3:0] sp8;
  logic       full8, ovf8, init8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_stack_ram_if #(.WORD_W(16), .DEPTH(256), .INSTR_WORDS(2)) bus ();
  instr_stack_ram_if #(.WORD_W(16), .DEPTH(8),   .INSTR_WORDS(2)) bus8 ();

  instr_stack_ram #(.WORD_W(16), .DEPTH(256), .INSTR_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clear(clear),
    .sp(sp), .full(full), .ld_overflow(ld_overflow), .initialized(initialized)
  );

  instr_stack_ram #(.WORD_W(16), .DEPTH(8), .INSTR_WORDS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave), .clear(clear8),
    .sp(sp8), .full(full8), .ld_overflow(ovf8), .initialized(init8)
  );

  typedef struct {
    logic        lv;
    logic [15:0] ld;
    logic        ll;
    logic        clr;
    logic        fr;
    logic [7:0]  fa;
    logic [8:0]  e_sp;
    logic        e_rdy;
    logic        e_init;
    logic        e_fv;
    logic        e_ferr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic lv, logic [15:0] ld, logic ll, logic clr,
                              logic fr, logic [7:0] fa, logic [8:0] e_sp,
                              logic e_rdy, logic e_init, logic e_fv,
                              logic e_ferr, logic [31:0] e_instr);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.clr = clr; v.fr = fr; v.fa = fa;
    v.e_sp = e_sp; v.e_rdy = e_rdy; v.e_init = e_init; v.e_fv = e_fv;
    v.e_ferr = e_ferr; v.e_instr = e_instr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " sp"},          64'(sp), 64'd0);
    check({tag, " full"},        64'(full), 64'd0);
    check({tag, " ld_ready"},    64'(bus.ld_ready), 64'd1);
    check({tag, " initialized"}, 64'(initialized), 64'd0);
    check({tag, " ld_overflow"}, 64'(ld_overflow), 64'd0);
    check({tag, " fetch_valid"}, 64'(bus.fetch_valid), 64'd0);
    check({tag, " fetch_err"},   64'(bus.fetch_err), 64'd0);
    check({tag, " fetch_instr"}, 64'(bus.fetch_instr), 64'd0);
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; clear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus8.ld_valid = 1'b0; bus8.ld_data = '0; bus8.ld_last = 1'b0;
    bus8.fetch_req = 1'b0; bus8.fetch_addr = '0;

    //      lv  data     ll clr fr addr  sp  rdy ini fv err instr
    add(1'b0, 16'h0000, 0, 0, 1, 8'd0, 9'd0, 1, 0, 1, 1, 32'h0);        // fetch in LOAD
    add(1'b1, 16'h0000, 0, 0, 0, 8'd0, 9'd1, 1, 0, 0, 1, 32'h0);
    add(1'b1, 16'h0000, 0, 0, 0, 8'd0, 9'd2, 1, 0, 0, 1, 32'h0);
    add(1'b1, 16'h0000, 0, 0, 0, 8'd0, 9'd3, 1, 0, 0, 1, 32'h0);
    add(1'b1, 16'h7000, 0, 0, 0, 8'd0, 9'd4, 1, 0, 0, 1, 32'h0);
    add(1'b1, 16'h0002, 0, 0, 0, 8'd0, 9'd5, 1, 0, 0, 1, 32'h0);
    add(1'b1, 16'h0003, 1, 0, 0, 8'd0, 9'd6, 0, 1, 0, 1, 32'h0);        // last word
    add(1'b0, 16'h0000, 0, 0, 1, 8'd2, 9'd6, 0, 1, 1, 0, 32'h70000000);
    add(1'b0, 16'h0000, 0, 0, 1, 8'd4, 9'd6, 0, 1, 1, 0, 32'h00030002);
    add(1'b0, 16'h0000, 0, 0, 0, 8'd0, 9'd6, 0, 1, 0, 0, 32'h00030002); // held
    add(1'b0, 16'h0000, 0, 0, 1, 8'd5, 9'd6, 0, 1, 1, 1, 32'h0);        // 5+2 > 6
    add(1'b1, 16'hFFFF, 0, 0, 1, 8'd4, 9'd6, 0, 1, 1, 0, 32'h00030002); // ld ignored in RUN
    add(1'b0, 16'h0000, 0, 0, 1, 8'd3, 9'd6, 0, 1, 1, 0, 32'h00027000);
    add(1'b0, 16'h0000, 0, 1, 1, 8'd2, 9'd0, 1, 0, 0, 0, 32'h00027000); // clear in RUN
    add(1'b1, 16'hAAAA, 0, 1, 0, 8'd0, 9'd0, 1, 0, 0, 0, 32'h00027000); // clear beats push
    add(1'b1, 16'h1111, 0, 0, 0, 8'd0, 9'd1, 1, 0, 0, 0, 32'h00027000);
    add(1'b1, 16'h2222, 1, 0, 0, 8'd0, 9'd2, 0, 1, 0, 0, 32'h00027000);
    add(1'b0, 16'h0000, 0, 0, 1, 8'd0, 9'd2, 0, 1, 1, 0, 32'h22221111);
    add(1'b0, 16'h0000, 0, 0, 1, 8'd1, 9'd2, 0, 1, 1, 1, 32'h0);        // 1+2 > 2

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset sp8", 64'(sp8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.ld_valid   = vecs[i].lv;
      bus.ld_data    = vecs[i].ld;
      bus.ld_last    = vecs[i].ll;
      clear          = vecs[i].clr;
      bus.fetch_req  = vecs[i].fr;
      bus.fetch_addr = vecs[i].fa;
      @(posedge clk);
      #1;
      check($sformatf("v%0d sp", i),          64'(sp), 64'(vecs[i].e_sp));
      check($sformatf("v%0d ld_ready", i),    64'(bus.ld_ready), 64'(vecs[i].e_rdy));
      check($sformatf("v%0d initialized", i), 64'(initialized), 64'(vecs[i].e_init));
      check($sformatf("v%0d fetch_valid", i), 64'(bus.fetch_valid), 64'(vecs[i].e_fv));
      check($sformatf("v%0d fetch_err", i),   64'(bus.fetch_err), 64'(vecs[i].e_ferr));
      check($sformatf("v%0d fetch_instr", i), 64'(bus.fetch_instr), 64'(vecs[i].e_instr));
    end
    idle_inputs();

    // DEPTH=8: fill without ld_last, then overflow.
    for (int i = 0; i < 8; i++) begin
      bus8.ld_valid = 1'b1;
      bus8.ld_data  = 16'(i + 16'h0100);
      @(posedge clk);
      #1;
    end
    check("d8 sp full",     64'(sp8), 64'd8);
    check("d8 full",        64'(full8), 64'd1);
    check("d8 ld_ready",    64'(bus8.ld_ready), 64'd0);
    check("d8 ovf before",  64'(ovf8), 64'd0);
    @(posedge clk);
    #1;
    check("d8 ovf after 9th", 64'(ovf8), 64'd1);
    check("d8 sp after 9th",  64'(sp8), 64'd8);
    check("d8 init after 9th", 64'(init8), 64'd0);
    bus8.ld_valid  = 1'b0;
    bus8.fetch_req = 1'b1;
    @(posedge clk);
    #1;
    check("d8 fetch in LOAD valid", 64'(bus8.fetch_valid), 64'd1);
    check("d8 fetch in LOAD err",   64'(bus8.fetch_err), 64'd1);
    check("d8 ovf sticky",          64'(ovf8), 64'd1);
    bus8.fetch_req = 1'b0;
    clear8 = 1'b1;
    @(posedge clk);
    #1;
    clear8 = 1'b0;
    check("d8 clear sp",       64'(sp8), 64'd0);
    check("d8 clear ovf",      64'(ovf8), 64'd0);
    check("d8 clear full",     64'(full8), 64'd0);
    check("d8 clear ld_ready", 64'(bus8.ld_ready), 64'd1);

    // Reset mid-cycle after three pushes with a pending erroneous response.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_data   = 16'(16'h0A00 + i);
      bus.fetch_req = (i == 2);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("pre-reset sp",        64'(sp), 64'd3);
    check("pre-reset fetch_err", 64'(bus.fetch_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_stack_ram.md
INSTR_STACK_RAM -- requirements
Module: instr_stack_ram

Interface
REQ-001 SHALL have parameter WORD_W, default 16, width of one stored word.
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two, >= 4); AW = log2(DEPTH).
REQ-003 SHALL have parameter INSTR_WORDS, default 2, words per fetched instruction (1..4).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ld_valid  in  1  load word offered.
REQ-007 SHALL have port ld_data  in  WORD_W  load word.
REQ-008 SHALL have port ld_last  in  1  offered word is the final program word.
REQ-009 SHALL have port ld_ready  out  1  load word accepted this cycle if ld_valid.
REQ-010 SHALL have port clear  in  1  discard program, return to loading.
REQ-011 SHALL have port sp  out  AW+1  stack pointer = count of words loaded.
REQ-012 SHALL have port full  out  1  sp == DEPTH.
REQ-013 SHALL have port ld_overflow  out  1  sticky: word offered while full.
REQ-014 SHALL have port initialized  out  1  program complete, execution may start.
REQ-015 SHALL have port fetch_req  in  1  fetch request.
REQ-016 SHALL have port fetch_addr  in  AW  word address of first instruction word.
REQ-017 SHALL have port fetch_valid  out  1  fetch response strobe.
REQ-018 SHALL have port fetch_instr  out  WORD_W*INSTR_WORDS  fetched instruction.
REQ-019 SHALL have port fetch_err  out  1  response invalid (qualifies fetch_valid).

Function
REQ-020 SHALL implement FSM states LOAD and RUN; initialized = (state == RUN).
REQ-021 SHALL drive ld_ready = (state == LOAD) && !full, combinationally.
REQ-022 SHALL, on ld_valid && ld_ready, write ld_data to mem[sp] and increment sp by 1.
REQ-023 SHALL move LOAD -> RUN on the edge where a word with ld_last=1 is accepted; sp includes that word.
REQ-024 SHALL set ld_overflow when ld_valid=1 in LOAD with full=1; no write, sp unchanged, state remains LOAD.
REQ-025 SHALL, on clear=1 in either state, next cycle set sp=0, state=LOAD, ld_overflow=0; clear overrides a simultaneous accepted push and fetch (no write, fetch_valid=0 next cycle).
REQ-026 SHALL respond to fetch_req exactly one cycle later with fetch_valid=1 for one cycle; back-to-back requests give back-to-back responses.
REQ-027 SHALL place mem[fetch_addr+k] in fetch_instr slice [k*WORD_W +: WORD_W], k = 0..INSTR_WORDS-1.
REQ-028 SHALL assert fetch_err, with fetch_instr = 0, when state != RUN at request, or fetch_addr + INSTR_WORDS > sp (no address wrap-around).
REQ-029 SHALL hold fetch_instr and fetch_err between responses; fetch_valid is 0 when no response.
REQ-030 SHALL ignore ld_valid in RUN (ld_ready=0, no write).

Reset
REQ-031 SHALL, while rst_n=0, force state=LOAD, sp=0, ld_overflow=0, fetch_valid=0, fetch_err=0, fetch_instr=0; full=0, ld_ready=1, initialized=0.
REQ-032 SHALL not reset memory contents; reset mid-load or mid-fetch discards progress and any pending response.

Structure
REQ-033 SHALL take FSM state encoding and default WORD_W/DEPTH/INSTR_WORDS from the shared cpu package.
REQ-034 SHALL use one sub-module, stack_mem: single write port, INSTR_WORDS-wide registered read port.

Verification
REQ-035 SHALL cover: push 0x0000,0x0000,0x0000,0x7000,0x0002,0x0003 (ld_last on last) -> sp=6, initialized=1 on following cycle.
REQ-036 SHALL cover: after REQ-035, fetch_addr=2 -> next cycle fetch_valid=1, fetch_instr=0x70000000, fetch_err=0; fetch_addr=4 -> 0x00030002.
REQ-037 SHALL cover: after REQ-035, fetch_addr=5 -> fetch_err=1, fetch_instr=0; fetch during LOAD -> fetch_err=1.
REQ-038 SHALL cover: DEPTH=8, push 8 words without ld_last -> full=1, ld_ready=0; 9th offer -> ld_overflow=1, sp=8.
REQ-039 SHALL cover: clear same cycle as accepted push in LOAD -> sp=0, no write; clear in RUN -> initialized=0, ld_ready=1.
REQ-040 SHALL cover: rst_n low after 3 pushes, mid-cycle -> outputs immediately at reset values, sp=0.
